// File: rtl/spi_master_nch.sv
// SPI master driving NUM_SS active-low chip selects, with optional
// MISO-low ready wait after select and optional chip-select hold between transfers.
module spi_master_nch #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SS     = 4,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned WAIT_RDY   = 1,
    localparam int unsigned SSW       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [SSW-1:0]        ss_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic                  hold_ss,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sck,
    output logic [NUM_SS-1:0]     ss_n,
    output logic                  busy,
    output logic                  chip_rdy,
    output logic                  new_data,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned HALF_CNT = 2 * DATA_WIDTH;
    localparam int unsigned HW       = $clog2(HALF_CNT);
    localparam int unsigned DIVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SELW     = SSW + 1;

    localparam logic [SELW-1:0] NUM_SS_W  = SELW'(NUM_SS);
    localparam logic [HW-1:0]   LAST_HALF = HW'(HALF_CNT - 1);
    localparam logic [DIVW-1:0] LAST_DIV  = DIVW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SS_SETUP,
        S_WAIT_RDY,
        S_XFER,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_accept;

    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [SSW-1:0]        r_sel;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_lsb;
    logic                  r_hold;
    logic                  r_held_vld;
    logic [SSW-1:0]        r_held_sel;
    logic [DIVW-1:0]       r_div_cnt;
    logic [HW-1:0]         r_half;

    logic                  r_sck;
    logic                  r_mosi;
    logic [NUM_SS-1:0]     r_ss_n;
    logic                  r_busy;
    logic                  r_chip_rdy;
    logic                  r_new_data;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic                  w_sel_ok;
    logic                  w_skip_wait;
    logic                  w_half_end;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_last;
    logic                  w_enter_xfer;
    logic                  w_emit;
    logic                  w_sample;
    logic                  w_tx_head;
    logic [DATA_WIDTH-1:0] w_tx_shift;
    logic [DATA_WIDTH-1:0] w_rx_shift;
    logic [NUM_SS-1:0]     w_req_mask;
    logic [NUM_SS-1:0]     w_cur_mask;

    assign w_sel_ok     = (SELW'(ss_sel) < NUM_SS_W);
    assign w_skip_wait  = (WAIT_RDY == 0) || (r_held_vld && (r_held_sel == r_sel));
    assign w_half_end   = (r_state == S_XFER) && (r_div_cnt == LAST_DIV);
    assign w_lead       = w_half_end && !r_half[0];
    assign w_trail      = w_half_end && r_half[0];
    assign w_last       = w_trail && (r_half == LAST_HALF);
    assign w_enter_xfer = (r_state != S_XFER) && (w_next_state == S_XFER);

    // cpha=0 presents the first bit on entry and shifts on trailing edges;
    // cpha=1 presents every bit on a leading edge.
    assign w_emit   = (w_enter_xfer && !r_cpha) || (w_lead && r_cpha) ||
                      (w_trail && !r_cpha && !w_last);
    assign w_sample = (w_lead && !r_cpha) || (w_trail && r_cpha);

    assign w_tx_head  = r_lsb ? r_tx[0] : r_tx[DATA_WIDTH-1];
    assign w_tx_shift = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    assign w_rx_shift = r_lsb ? {miso, r_rx[DATA_WIDTH-1:1]} : {r_rx[DATA_WIDTH-2:0], miso};

    assign w_req_mask = NUM_SS'(1) << ss_sel;
    assign w_cur_mask = NUM_SS'(1) << r_sel;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a start with an out-of-range select is dropped
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_sel_ok) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SS_SETUP;
                end
            end
            S_SS_SETUP: w_next_state = w_skip_wait ? S_XFER : S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (!miso) begin
                    w_next_state = S_XFER;
                end
            end
            S_XFER: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Serial engine: request latch, SCLK timing, MOSI shift-out, MISO shift-in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_sel     <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            r_hold    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_div_cnt <= '0;
            r_half    <= '0;
        end else begin
            if (w_accept) begin
                r_tx   <= data_in;
                r_sel  <= ss_sel;
                r_cpol <= cpol;
                r_cpha <= cpha;
                r_lsb  <= lsb_first;
                r_hold <= hold_ss;
                r_sck  <= cpol;
            end

            if (r_state != S_XFER) begin
                r_div_cnt <= '0;
                r_half    <= '0;
            end else if (w_half_end) begin
                r_div_cnt <= '0;
                r_half    <= r_half + HW'(1);
                r_sck     <= ~r_sck;
            end else begin
                r_div_cnt <= r_div_cnt + DIVW'(1);
            end

            if (w_emit) begin
                r_mosi <= w_tx_head;
                r_tx   <= w_tx_shift;
            end else if (w_next_state != S_XFER) begin
                r_mosi <= 1'b0;
            end

            if (w_sample) begin
                r_rx <= w_rx_shift;
            end
        end
    end

    // Chip selects: switching lines happens in one update; held line remembered at DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_n     <= '1;
            r_held_vld <= 1'b0;
            r_held_sel <= '0;
        end else if (w_accept) begin
            r_ss_n <= ~w_req_mask;
        end else if (r_state == S_DONE) begin
            if (!r_hold) begin
                r_ss_n <= '1;
            end
            r_held_vld <= r_hold;
            r_held_sel <= r_sel;
        end
    end

    // Status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_new_data <= 1'b0;
            r_data_out <= '0;
            r_chip_rdy <= 1'b0;
        end else begin
            r_busy     <= (w_next_state != S_IDLE);
            r_new_data <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_data_out <= r_rx;
            end
            r_chip_rdy <= ((r_ss_n & w_cur_mask) == '0) && !miso;
        end
    end

    assign mosi     = r_mosi;
    assign sck      = r_sck;
    assign ss_n     = r_ss_n;
    assign busy     = r_busy;
    assign chip_rdy = r_chip_rdy;
    assign new_data = r_new_data;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_spi_master_nch.sv
// Self-checking bench for spi_master_nch: directed scenarios plus randomized
// transfers against a bit-list SPI slave/observer model.
module tb_spi_master_nch;

    localparam int unsigned DW  = 8;
    localparam int unsigned NSS = 5;
    localparam int unsigned DIV = 2;
    localparam int unsigned SSW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [DW-1:0]  data_in;
    logic [SSW-1:0] ss_sel;
    logic           cpol;
    logic           cpha;
    logic           lsb_first;
    logic           hold_ss;
    logic           miso;
    logic           mosi;
    logic           sck;
    logic [NSS-1:0] ss_n;
    logic           busy;
    logic           chip_rdy;
    logic           new_data;
    logic [DW-1:0]  data_out;

    int n_tests  = 0;
    int n_fail   = 0;
    int held_sel = -1;

    spi_master_nch #(
        .DATA_WIDTH(DW),
        .NUM_SS    (NSS),
        .CLK_DIV   (DIV),
        .WAIT_RDY  (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .ss_sel   (ss_sel),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsb_first(lsb_first),
        .hold_ss  (hold_ss),
        .miso     (miso),
        .mosi     (mosi),
        .sck      (sck),
        .ss_n     (ss_n),
        .busy     (busy),
        .chip_rdy (chip_rdy),
        .new_data (new_data),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NSS-1:0] sel_mask(input int s);
        logic [NSS-1:0] m;
        m    = '1;
        m[s] = 1'b0;
        return m;
    endfunction

    // k-th bit on the wire for a word in the given order
    function automatic logic wire_bit(input logic [DW-1:0] w, input bit lsb, input int k);
        return lsb ? w[k] : w[DW-1-k];
    endfunction

    function automatic logic [DW-1:0] put_bit(input logic [DW-1:0] w, input logic b,
                                              input bit lsb, input int k);
        logic [DW-1:0] r;
        r = w;
        r[lsb ? k : DW-1-k] = b;
        return r;
    endfunction

    // One transfer with a model slave. rdy_dly: cycles miso stays high after select.
    // poke: extra start pulse while busy. abort_half >= 0: assert rst in that half-period.
    task automatic run_xfer(input logic [DW-1:0] din, input int sel, input bit pol, input bit pha,
                            input bit lsb, input bit hold, input logic [DW-1:0] sword,
                            input int rdy_dly, input bit poke, input int abort_half);
        bit            skip;
        bit            lead;
        bit            aborted;
        int            xfer_edge;
        int            exp_nd;
        int            abort_cyc;
        int            nd_cyc;
        int            nd_cnt;
        int            si;
        int            mi;
        logic          prev_sck;
        logic          prev_mosi;
        logic [DW-1:0] mword;

        skip      = (held_sel == sel);
        xfer_edge = skip ? 1 : ((rdy_dly + 1 > 2) ? rdy_dly + 1 : 2);
        exp_nd    = xfer_edge + 2 * DW * DIV + 1;
        abort_cyc = (abort_half >= 0) ? xfer_edge + abort_half * DIV : -1;
        nd_cyc    = -1;
        nd_cnt    = 0;
        si        = 0;
        mi        = 0;
        mword     = '0;
        aborted   = 1'b0;

        data_in   = din;
        ss_sel    = SSW'(sel);
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        hold_ss   = hold;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!skip) miso = (rdy_dly > 0);
        check_eq("setup_ss_n", 32'(ss_n), 32'(sel_mask(sel)));
        check_eq("setup_sck", 32'(sck), 32'(pol));
        check_eq("setup_busy", 32'(busy), 32'd1);
        check_eq("setup_mosi", 32'(mosi), 32'd0);
        prev_sck  = sck;
        prev_mosi = mosi;

        for (int cyc = 1; cyc <= exp_nd + 3; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == abort_cyc) begin
                #2 rst = 1'b1;
                #1;
                check_eq("rst_async_outputs",
                         32'({ss_n, sck, mosi, busy, new_data, chip_rdy, data_out}),
                         32'({{NSS{1'b1}}, 5'b0, {DW{1'b0}}}));
                aborted = 1'b1;
                break;
            end
            if (new_data) begin
                nd_cnt++;
                if (nd_cyc < 0) nd_cyc = cyc;
            end
            if (!skip && rdy_dly >= 20 && cyc == rdy_dly - 1) begin
                check_eq("wait_sck", 32'(sck), 32'(pol));
                check_eq("wait_busy", 32'(busy), 32'd1);
                check_eq("wait_chip_rdy", 32'(chip_rdy), 32'd0);
            end
            if (!skip && cyc == rdy_dly && rdy_dly > 0) miso = 1'b0;
            if (cyc == xfer_edge) begin
                if (!skip && rdy_dly >= 20) check_eq("rdy_chip_rdy", 32'(chip_rdy), 32'd1);
                check_eq("xfer_ss_n", 32'(ss_n), 32'(sel_mask(sel)));
                if (!pha) begin
                    miso = wire_bit(sword, lsb, 0);
                    si   = 1;
                end
            end
            if (sck !== prev_sck) begin
                lead = (prev_sck === pol);
                if ((pha ? !lead : lead) && mi < DW) begin
                    mword = put_bit(mword, prev_mosi, lsb, mi);
                    mi++;
                end
                if ((pha ? lead : !lead) && si < DW) begin
                    miso = wire_bit(sword, lsb, si);
                    si++;
                end
            end
            if (poke && cyc == 10) begin
                start   = 1'b1;
                data_in = ~din;
                ss_sel  = SSW'((sel + 1) % NSS);
            end
            if (poke && cyc == 11) start = 1'b0;
            prev_sck  = sck;
            prev_mosi = mosi;
        end

        if (aborted) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            miso = 1'b0;
            nd_cnt = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (new_data) nd_cnt++;
            end
            check_eq("abort_no_new_data", 32'(nd_cnt), 32'd0);
            check_eq("abort_idle_busy", 32'(busy), 32'd0);
            held_sel = -1;
        end else begin
            check_eq("nd_latency", 32'(nd_cyc), 32'(exp_nd));
            check_eq("nd_pulses", 32'(nd_cnt), 32'd1);
            check_eq("data_out", 32'(data_out), 32'(sword));
            check_eq("mosi_word", 32'(mword), 32'(din));
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_mosi", 32'(mosi), 32'd0);
            check_eq("idle_sck", 32'(sck), 32'(pol));
            check_eq("idle_ss_n", 32'(ss_n), hold ? 32'(sel_mask(sel)) : 32'({NSS{1'b1}}));
            held_sel = hold ? sel : -1;
        end
    endtask

    // Hard stop should anything stall
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] keep_out;
        int            nd_seen;

        rst       = 1'b1;
        start     = 1'b0;
        data_in   = '0;
        ss_sel    = '0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsb_first = 1'b0;
        hold_ss   = 1'b0;
        miso      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs",
                 32'({ss_n, sck, mosi, busy, new_data, chip_rdy, data_out}),
                 32'({{NSS{1'b1}}, 5'b0, {DW{1'b0}}}));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Mode 0 MSB-first reference transfer
        run_xfer(8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1'b0, -1);
        // Mode 3 LSB-first
        run_xfer(8'h01, 3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 1'b0, -1);
        // Slave not ready for 50 cycles
        run_xfer(8'h5A, 3, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 50, 1'b0, -1);
        // Hold line 2, reuse it without ready wait, then move to line 0
        run_xfer(8'h96, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1, 1'b0, -1);
        run_xfer(8'h69, 2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E, 0, 1'b0, -1);
        run_xfer(8'hF0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 2, 1'b0, -1);

        // Out-of-range selects are dropped
        keep_out = data_out;
        nd_seen  = 0;
        for (int s = NSS; s < 8; s++) begin
            ss_sel  = SSW'(s);
            data_in = 8'hFF;
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (new_data) nd_seen++;
            @(posedge clk);
            #1;
            if (new_data) nd_seen++;
            check_eq("bad_sel_busy", 32'(busy), 32'd0);
            check_eq("bad_sel_ss_n", 32'(ss_n), 32'({NSS{1'b1}}));
        end
        check_eq("bad_sel_no_new_data", 32'(nd_seen), 32'd0);
        check_eq("bad_sel_data_out", 32'(data_out), 32'(keep_out));

        // Start while busy is ignored
        run_xfer(8'h33, 4, 1'b0, 1'b0, 1'b0, 1'b0, 8'hCC, 0, 1'b1, -1);

        // Reset during half-period 7, then a clean transfer on the previously held line
        run_xfer(8'hE7, 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h18, 0, 1'b0, 7);
        run_xfer(8'h42, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h24, 0, 1'b0, -1);

        // Randomized transfers
        for (int t = 0; t < 30; t++) begin
            run_xfer(DW'($urandom), int'($urandom_range(0, NSS - 1)),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     DW'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) == 0), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
